sysarray_os_ctrl: RTL and testbench
===================================

// Module: sysarray_os_ctrl
// PURPOSE
//  Parametrised output-stationary ROWS x COLS systolic MAC array with a built-in control FSM.
//  Streams K column/row vectors of A (ROWS lanes) and B (COLS lanes) through the mesh, skewing them internally.
//  Each PE(r,c) accumulates C[r][c] = sum_k A[r][k]*B[k][c]; results are drained one row per beat.
//  Next-generation replacement for the fixed 4x3 array in the accelerator datapath.
// PARAMETERS
//  DATA_W  8          operand width (bits)
//  ROWS    4          array rows (A lanes), >=1
//  COLS    3          array columns (B lanes), >=1
//  K_MAX   255        max reduction length per job
//  ACC_W   2*DATA_W+8 accumulator width per PE
// PORTS
//  clk       in   1                clock, all state on posedge
//  reset     in   1                synchronous, active-high; clears all state
//  start     in   1                job request; sampled only in IDLE
//  k_len     in   $clog2(K_MAX+1)  reduction length, latched on accepted start
//  in_valid  in   1                a_in/b_in carry vector k
//  in_ready  out  1                high only in LOAD
//  a_in      in   ROWS*DATA_W      lane r = A[r][k] at bits [r*DATA_W +: DATA_W]
//  b_in      in   COLS*DATA_W      lane c = B[k][c]
//  busy      out  1                high in every state except IDLE
//  c_valid   out  1                c_row/c_data valid (DRAIN only)
//  c_ready   in   1                consumer accepts beat
//  c_row     out  $clog2(ROWS)     row index of current beat (0 when ROWS=1)
//  c_data    out  COLS*ACC_W       lane c = C[c_row][c]
//  done      out  1                one-cycle pulse after last beat accepted
// BEHAVIOUR
//  Reset: state=IDLE; in_ready, busy, c_valid, done, c_row = 0; c_data = 0;
//   all accumulators and skew/pipe registers = 0.
//  FSM IDLE -> LOAD -> FLUSH -> DRAIN -> IDLE.
//   IDLE:  start=1 latches k_len, clears all accumulators and skew regs.
//          Next state is LOAD, or FLUSH if k_len==0.
//   LOAD:  in_ready=1. Each in_valid&&in_ready beat advances the whole mesh one step
//          and increments the beat count. in_valid=0 stalls the mesh; no accumulate, no shift.
//          After beat k_len-1 is accepted -> FLUSH.
//   FLUSH: mesh advances every cycle with zero operands for exactly ROWS+COLS-1 cycles -> DRAIN.
//   DRAIN: c_valid=1, c_row=0..ROWS-1; c_data holds the row stable while c_ready=0.
//          A beat transfers on c_valid&&c_ready. After row ROWS-1 transfers: done=1 for one cycle
//          (the cycle in IDLE), then IDLE.
//  Skew: A lane r is delayed r steps before PE(r,0); B lane c is delayed c steps before PE(0,c).
//   Operands move right/down one PE per mesh step.
//  PE step: acc += a*b; product is 2*DATA_W bits, extended to ACC_W; acc wraps mod 2^ACC_W.
//  Latency (in_valid and c_ready held high): accepted start -> first c_valid
//   = 1 + k_len + ROWS+COLS-1 cycles. Job total = that + ROWS cycles.
//  Boundaries:
//   - start while busy is ignored; start and done in the same cycle: start accepted (state is IDLE).
//   - in_valid outside LOAD is ignored; a_in/b_in are don't-care when not handshaken.
//   - k_len > K_MAX: clamped to K_MAX.
//   - k_len==0: drains all-zero results.
//   - reset mid-job (any state): aborts immediately to reset values; no done pulse.
// CONFIGURATION
//  SYSARRAY_SIGNED_EN defined:   operands are two's complement; signed multiply; product sign-extended to ACC_W.
//  SYSARRAY_SIGNED_EN undefined: operands unsigned; product zero-extended.
// TESTING
//  1 Default params, unsigned, k_len=3, A=[[1,2,3],[4,5,6],[7,8,9],[1,1,1]], B=3x3 identity
//    -> rows 0..3 = A rows, first c_valid 10 cycles after start.
//  2 k_len=4, in_valid toggled 1,0,1,0..., all A=B=1 -> every C=4; results identical to the ungapped run.
//  3 c_ready low 3 cycles on row 1 -> c_row/c_data stable; all 4 rows delivered once; single done pulse.
//  4 SIGNED_EN, k_len=2, A lanes=-1 (8'hFF), B lanes=2 -> every C=-4 (all ones except ...FC);
//    without macro: every C=2*255*2=1020.
//  5 k_len=K_MAX, A=B=255, unsigned -> C=255*65025=16581375 (fits ACC_W=24); no wrap.
//  6 Reset asserted in FLUSH -> next cycle all outputs 0, state IDLE;
//    new job k_len=1, A=B=3 -> every C=9 (no stale sums).

Source files
------------

// File: rtl/sysarray_os_ctrl.sv
// Output-stationary ROWS x COLS systolic MAC array with LOAD/FLUSH/DRAIN control FSM.
// Define SYSARRAY_SIGNED_EN for two's-complement operands; default build is unsigned.
module sysarray_os_ctrl #(
    parameter int DATA_W = 8,
    parameter int ROWS   = 4,
    parameter int COLS   = 3,
    parameter int K_MAX  = 255,
    parameter int ACC_W  = 2*DATA_W+8,
    localparam int KW    = $clog2(K_MAX+1),
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [KW-1:0]           k_len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ROWS*DATA_W-1:0]  a_in,
    input  logic [COLS*DATA_W-1:0]  b_in,
    output logic                    busy,
    output logic                    c_valid,
    input  logic                    c_ready,
    output logic [RW-1:0]           c_row,
    output logic [COLS*ACC_W-1:0]   c_data,
    output logic                    done
);

    localparam int FW    = $clog2(ROWS+COLS);
    localparam int CNT_W = (KW > FW) ? KW : FW;
    localparam int SKA_N = (ROWS > 1) ? (ROWS*(ROWS-1))/2 : 1;
    localparam int SKB_N = (COLS > 1) ? (COLS*(COLS-1))/2 : 1;
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(ROWS+COLS-2);
    localparam logic [KW:0]      K_CAP      = (KW+1)'(K_MAX);
    localparam logic [RW-1:0]    ROW_LAST   = RW'(ROWS-1);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      k_lat;
    logic [KW-1:0]         k_eff;

    logic                  step;
    logic                  clear;
    logic [ROWS*DATA_W-1:0] a_src;
    logic [COLS*DATA_W-1:0] b_src;

    // Triangular skew storage: lane r owns r consecutive slots starting at r*(r-1)/2.
    logic [SKA_N*DATA_W-1:0] a_sk;
    logic [SKB_N*DATA_W-1:0] b_sk;

    logic [DATA_W-1:0] a_edge [ROWS];
    logic [DATA_W-1:0] b_edge [COLS];
    logic [DATA_W-1:0] a_reg  [ROWS][COLS];
    logic [DATA_W-1:0] b_reg  [ROWS][COLS];
    logic [ACC_W-1:0]  acc      [ROWS][COLS];
    logic [ACC_W-1:0]  acc_next [ROWS][COLS];

    logic [COLS*ACC_W-1:0] first_row;
    logic [COLS*ACC_W-1:0] next_row;
    logic [RW-1:0]         next_idx;

    function automatic logic [ACC_W-1:0] mac_prod(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
`ifdef SYSARRAY_SIGNED_EN
        logic signed [2*DATA_W-1:0] p;
        p = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
        return ACC_W'(p);
`else
        logic [2*DATA_W-1:0] p;
        p = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        return ACC_W'(p);
`endif
    endfunction

    always_comb begin
        step  = ((state == LOAD) && in_valid) || (state == FLUSH);
        clear = (state == IDLE) && start;
        a_src = (state == LOAD) ? a_in : '0;
        b_src = (state == LOAD) ? b_in : '0;
        k_eff = ({1'b0, k_len} > K_CAP) ? K_CAP[KW-1:0] : k_len;

        a_edge[0] = a_src[DATA_W-1:0];
        for (int unsigned r = 1; r < ROWS; r++)
            a_edge[r] = a_sk[((r*(r+1))/2 - 1)*DATA_W +: DATA_W];
        b_edge[0] = b_src[DATA_W-1:0];
        for (int unsigned c = 1; c < COLS; c++)
            b_edge[c] = b_sk[((c*(c+1))/2 - 1)*DATA_W +: DATA_W];

        for (int unsigned r = 0; r < ROWS; r++)
            for (int unsigned c = 0; c < COLS; c++)
                acc_next[r][c] = acc[r][c] + mac_prod(a_reg[r][c], b_reg[r][c]);

        next_idx = (c_row == ROW_LAST) ? '0 : c_row + RW'(1);
        for (int unsigned c = 0; c < COLS; c++) begin
            first_row[c*ACC_W +: ACC_W] = acc_next[0][c];
            next_row[c*ACC_W +: ACC_W]  = acc[next_idx][c];
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            a_sk <= '0;
            b_sk <= '0;
            for (int unsigned r = 0; r < ROWS; r++)
                for (int unsigned c = 0; c < COLS; c++) begin
                    a_reg[r][c] <= '0;
                    b_reg[r][c] <= '0;
                    acc[r][c]   <= '0;
                end
        end else if (step) begin
            for (int unsigned r = 1; r < ROWS; r++) begin
                a_sk[((r*(r-1))/2)*DATA_W +: DATA_W] <= a_src[r*DATA_W +: DATA_W];
                for (int unsigned i = 1; i < r; i++)
                    a_sk[((r*(r-1))/2 + i)*DATA_W +: DATA_W] <=
                        a_sk[((r*(r-1))/2 + i - 1)*DATA_W +: DATA_W];
            end
            for (int unsigned c = 1; c < COLS; c++) begin
                b_sk[((c*(c-1))/2)*DATA_W +: DATA_W] <= b_src[c*DATA_W +: DATA_W];
                for (int unsigned i = 1; i < c; i++)
                    b_sk[((c*(c-1))/2 + i)*DATA_W +: DATA_W] <=
                        b_sk[((c*(c-1))/2 + i - 1)*DATA_W +: DATA_W];
            end
            for (int unsigned r = 0; r < ROWS; r++) begin
                a_reg[r][0] <= a_edge[r];
                for (int unsigned c = 1; c < COLS; c++)
                    a_reg[r][c] <= a_reg[r][c-1];
            end
            for (int unsigned c = 0; c < COLS; c++) begin
                b_reg[0][c] <= b_edge[c];
                for (int unsigned r = 1; r < ROWS; r++)
                    b_reg[r][c] <= b_reg[r-1][c];
            end
            for (int unsigned r = 0; r < ROWS; r++)
                for (int unsigned c = 0; c < COLS; c++)
                    acc[r][c] <= acc_next[r][c];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            k_lat    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            c_valid  <= 1'b0;
            c_row    <= '0;
            c_data   <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        k_lat <= CNT_W'(k_eff);
                        cnt   <= '0;
                        busy  <= 1'b1;
                        if (k_eff == '0) begin
                            state <= FLUSH;
                        end else begin
                            state    <= LOAD;
                            in_ready <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        if (cnt == k_lat - CNT_W'(1)) begin
                            cnt      <= '0;
                            in_ready <= 1'b0;
                            state    <= FLUSH;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                FLUSH: begin
                    // The final flush step still updates row 0, so present its next value.
                    if (cnt == FLUSH_LAST) begin
                        cnt     <= '0;
                        state   <= DRAIN;
                        c_valid <= 1'b1;
                        c_row   <= '0;
                        c_data  <= first_row;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    if (c_ready) begin
                        if (c_row == ROW_LAST) begin
                            state   <= IDLE;
                            c_valid <= 1'b0;
                            c_row   <= '0;
                            c_data  <= '0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            c_row  <= next_idx;
                            c_data <= next_row;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sysarray_os_ctrl.sv
// Directed self-checking bench for sysarray_os_ctrl at default parameters (4x3, 8-bit, 24-bit acc).
module tb_sysarray_os_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  k_len;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_in;
    logic [23:0] b_in;
    logic        busy;
    logic        c_valid;
    logic        c_ready;
    logic [1:0]  c_row;
    logic [71:0] c_data;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] a_vec [8];
    logic [23:0] b_vec [8];
    logic [71:0] got   [4];
    time         t0, t_valid, t_done;

    always #5 clk = ~clk;

    sysarray_os_ctrl #(
        .DATA_W(8),
        .ROWS  (4),
        .COLS  (3),
        .K_MAX (255),
        .ACC_W (24)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .k_len   (k_len),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a_in    (a_in),
        .b_in    (b_in),
        .busy    (busy),
        .c_valid (c_valid),
        .c_ready (c_ready),
        .c_row   (c_row),
        .c_data  (c_data),
        .done    (done)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] row3(input int l0, input int l1, input int l2);
        return {24'(l2), 24'(l1), 24'(l0)};
    endfunction

    task automatic set_vecs(input logic [31:0] a, input logic [23:0] b);
        for (int i = 0; i < 8; i++) begin
            a_vec[i] = a;
            b_vec[i] = b;
        end
    endtask

    task automatic load_identity_job;
        // beat k: a lanes = column k of A, b lanes = row k of identity
        a_vec[0] = 32'h01070401;
        a_vec[1] = 32'h01080502;
        a_vec[2] = 32'h01090603;
        b_vec[0] = 24'h000001;
        b_vec[1] = 24'h000100;
        b_vec[2] = 24'h010000;
    endtask

    task automatic start_job(input int k);
        start = 1'b1;
        k_len = 8'(k);
        t0    = $time;
        step;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("done_after_start", done, 0);
    endtask

    task automatic feed(input int k, input bit gaps);
        for (int i = 0; i < k; i++) begin
            chk("in_ready_load", in_ready, 1);
            in_valid = 1'b1;
            a_in     = a_vec[i % 8];
            b_in     = b_vec[i % 8];
            step;
            in_valid = 1'b0;
            a_in     = 32'hDEADBEEF;
            b_in     = 24'hC0FFEE;
            if (gaps) step;
        end
    endtask

    task automatic drain(input int stall_row, input int stall_n);
        int          n;
        logic [71:0] hold;
        n       = 0;
        c_ready = 1'b1;
        while (c_valid !== 1'b1 && n < 2000) begin
            step;
            n++;
        end
        t_valid = $time;
        chk("c_valid_up", c_valid, 1);
        for (int row = 0; row < 4; row++) begin
            if (row == stall_row) begin
                hold    = c_data;
                c_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    step;
                    chk("stall_valid", c_valid, 1);
                    chk("stall_row", c_row, row);
                    chk("stall_data", c_data, hold);
                end
                c_ready = 1'b1;
            end
            chk("c_row", c_row, row);
            got[row] = c_data;
            step;
        end
        t_done = $time;
        chk("done_pulse", done, 1);
        chk("busy_end", busy, 0);
        chk("c_valid_end", c_valid, 0);
    endtask

    task automatic check_uniform(input string tag, input int v);
        for (int r = 0; r < 4; r++) chk(tag, got[r], row3(v, v, v));
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        k_len    = '0;
        in_valid = 1'b0;
        a_in     = '0;
        b_in     = '0;
        c_ready  = 1'b0;
        step; step; step;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_c_valid", c_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_c_row", c_row, 0);
        chk("rst_c_data", c_data, 0);
        reset = 1'b0;
        step;

        // A (4x3) times identity, no gaps: latency 10, job 14
        load_identity_job();
        start_job(3);
        feed(3, 0);
        chk("in_ready_flush", in_ready, 0);
        drain(-1, 0);
        chk("lat_first_valid", (t_valid - t0) / 10, 10);
        chk("lat_done", (t_done - t0) / 10, 14);
        chk("ident_r0", got[0], row3(1, 2, 3));
        chk("ident_r1", got[1], row3(4, 5, 6));
        chk("ident_r2", got[2], row3(7, 8, 9));
        chk("ident_r3", got[3], row3(1, 1, 1));

        // Gapped input stream, all ones
        set_vecs(32'h01010101, 24'h010101);
        start_job(4);
        feed(4, 1);
        drain(-1, 0);
        check_uniform("gapped_ones", 4);

        // Output back-pressure on row 1; in_valid and start during FLUSH are ignored
        load_identity_job();
        start_job(3);
        feed(3, 0);
        start    = 1'b1;
        in_valid = 1'b1;
        a_in     = 32'hFFFFFFFF;
        b_in     = 24'hFFFFFF;
        step; step;
        start    = 1'b0;
        in_valid = 1'b0;
        chk("busy_flush", busy, 1);
        drain(1, 3);
        chk("stall_r0", got[0], row3(1, 2, 3));
        chk("stall_r1", got[1], row3(4, 5, 6));
        chk("stall_r2", got[2], row3(7, 8, 9));
        chk("stall_r3", got[3], row3(1, 1, 1));

        // Start in the done cycle; 0xFF times 2 over two beats
        set_vecs(32'hFFFFFFFF, 24'h020202);
        start_job(2);
        feed(2, 0);
        drain(-1, 0);
`ifdef SYSARRAY_SIGNED_EN
        check_uniform("neg_product", -4);
`else
        check_uniform("ff_times_2", 1020);
`endif

        // Maximum length, maximum operands: 255 * 65025 without wrap
        set_vecs(32'hFFFFFFFF, 24'hFFFFFF);
        start_job(255);
        feed(255, 0);
        drain(-1, 0);
`ifdef SYSARRAY_SIGNED_EN
        check_uniform("kmax_signed", 255);
`else
        check_uniform("kmax_full", 16581375);
`endif

        // Zero-length job right after a large one: all-zero results, latency 7
        start_job(0);
        chk("k0_no_load", in_ready, 0);
        drain(-1, 0);
        chk("k0_latency", (t_valid - t0) / 10, 7);
        check_uniform("k0_zero", 0);

        // Reset in FLUSH aborts; following job sees no stale sums
        load_identity_job();
        step;
        start_job(3);
        feed(3, 0);
        step; step;
        reset = 1'b1;
        step;
        chk("abort_in_ready", in_ready, 0);
        chk("abort_busy", busy, 0);
        chk("abort_c_valid", c_valid, 0);
        chk("abort_done", done, 0);
        chk("abort_c_row", c_row, 0);
        chk("abort_c_data", c_data, 0);
        reset = 1'b0;
        step;
        step;
        chk("abort_no_done", done, 0);
        chk("abort_idle", busy, 0);
        set_vecs(32'h03030303, 24'h030303);
        start_job(1);
        feed(1, 0);
        drain(-1, 0);
        check_uniform("after_abort", 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no completion, expected finish before time limit");
        $fatal(1);
    end

endmodule
